// File: rtl/tt_bist_pkg.sv
// Shared types and constants for the truth-table BIST controller.
package tt_bist_pkg;

    // Controller states: idle, hold a vector while the unit under test settles,
    // one-cycle compare, results held.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Three inputs {A,B,C} give eight vectors.
    localparam int NUM_VECS = 8;

    // Truth table of F = A'BC + B'(AC'+A'C) + (ABC'+A'B')C', bit index = {A,B,C}.
    localparam logic [NUM_VECS-1:0] DEFAULT_EXPECTED = 8'h5B;

endpackage

// File: rtl/tt_bist.sv
// Exhaustive truth-table BIST for a 3-input, 1-output combinational unit.
// Each vector {A,B,C} is driven for SETTLE_CYCLES cycles (legal 1..15), then F
// is compared against EXPECTED in a single CHECK cycle. Error count and the
// first failing vector are held in DONE until the next start or reset.
// Optional build macro TT_BIST_STOP_ON_FAIL_EN: end the run at the first mismatch.
module tt_bist
    import tt_bist_pkg::*;
#(
    parameter logic [NUM_VECS-1:0] EXPECTED      = DEFAULT_EXPECTED,
    parameter int unsigned         SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       f_in,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic       fail_valid,
    output logic [2:0] fail_vec
);

    localparam logic [2:0] LAST_VEC = 3'(NUM_VECS - 1);
    localparam logic [3:0] RELOAD   = 4'(SETTLE_CYCLES - 1);

`ifdef TT_BIST_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    state_t     state, state_n;
    logic [2:0] vec, vec_n;
    logic [3:0] cnt, cnt_n;
    logic [3:0] err_n;
    logic       fail_valid_n;
    logic [2:0] fail_vec_n;
    logic       mismatch;

    // Stimulus is the registered vector index itself.
    assign a_out = vec[2];
    assign b_out = vec[1];
    assign c_out = vec[0];

    assign busy = (state == SETTLE) || (state == CHECK);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (err_count == 4'd0);

    // Case-inequality so an unknown F in simulation is treated as a mismatch.
    assign mismatch = (state == CHECK) && (f_in !== EXPECTED[vec]);

    // Register all controller state; reset clears every result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vec        <= 3'd0;
            cnt        <= 4'd0;
            err_count  <= 4'd0;
            fail_valid <= 1'b0;
            fail_vec   <= 3'd0;
        end else begin
            state      <= state_n;
            vec        <= vec_n;
            cnt        <= cnt_n;
            err_count  <= err_n;
            fail_valid <= fail_valid_n;
            fail_vec   <= fail_vec_n;
        end
    end

    // Next-state and result update: hold everything unless a state acts on it.
    always_comb begin
        state_n      = state;
        vec_n        = vec;
        cnt_n        = cnt;
        err_n        = err_count;
        fail_valid_n = fail_valid;
        fail_vec_n   = fail_vec;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n      = SETTLE;
                    vec_n        = 3'd0;
                    cnt_n        = RELOAD;
                    err_n        = 4'd0;
                    fail_valid_n = 1'b0;
                    fail_vec_n   = 3'd0;
                end
            end
            SETTLE: begin
                if (cnt == 4'd0) begin
                    state_n = CHECK;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    err_n = err_count + 4'd1;
                    if (!fail_valid) begin
                        fail_valid_n = 1'b1;
                        fail_vec_n   = vec;
                    end
                end
                if ((mismatch && STOP_ON_FAIL) || (vec == LAST_VEC)) begin
                    state_n = DONE;
                end else begin
                    state_n = SETTLE;
                    vec_n   = vec + 3'd1;
                    cnt_n   = RELOAD;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tt_bist.sv
// Self-checking bench for tt_bist: two instances (SETTLE_CYCLES 4 and 1) share
// reset and start. The unit under test is a lookup of the truth table tt on
// each instance's stimulus. A run-level model predicts every output per cycle.
module tb_tt_bist;
    localparam logic [7:0] EXP = 8'h5B;
`ifdef TT_BIST_STOP_ON_FAIL_EN
    localparam bit STOP_MODEL = 1'b1;
`else
    localparam bit STOP_MODEL = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] tt;
    logic       chk_en;

    logic [1:0] a_o, b_o, c_o, f_o, busy_o, done_o, pass_o, fv_o;
    logic [3:0] err_o [2];
    logic [2:0] fvec_o [2];

    int checks   = 0;
    int failures = 0;

    // Reference run state per instance: running flag, cycles since start, table.
    bit         m_run [2];
    int         m_k   [2];
    logic [7:0] m_tt  [2];

    assign f_o[0] = tt[{a_o[0], b_o[0], c_o[0]}];
    assign f_o[1] = tt[{a_o[1], b_o[1], c_o[1]}];

    tt_bist #(.EXPECTED(EXP), .SETTLE_CYCLES(4)) dut0 (
        .clk(clk), .rst(rst), .start(start), .f_in(f_o[0]),
        .a_out(a_o[0]), .b_out(b_o[0]), .c_out(c_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
        .err_count(err_o[0]), .fail_valid(fv_o[0]), .fail_vec(fvec_o[0])
    );

    tt_bist #(.EXPECTED(EXP), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .f_in(f_o[1]),
        .a_out(a_o[1]), .b_out(b_o[1]), .c_out(c_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
        .err_count(err_o[1]), .fail_valid(fv_o[1]), .fail_vec(fvec_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int settle_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int first_one(input logic [7:0] d);
        for (int v = 0; v < 8; v++) if (d[v]) return v;
        return 8;
    endfunction

    // Number of vectors a run applies, given the mismatch pattern.
    function automatic int vecs_in_run(input logic [7:0] d);
        int f;
        f = first_one(d);
        if (STOP_MODEL && f < 8) return f + 1;
        return 8;
    endfunction

    // Advance the reference on every rising edge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int len;
            len = vecs_in_run(m_tt[i] ^ EXP) * (settle_of(i) + 1);
            if (rst) begin
                m_run[i] = 1'b0;
                m_k[i]   = 0;
            end else if (start && !(m_run[i] && m_k[i] < len)) begin
                m_run[i] = 1'b1;
                m_k[i]   = 0;
                m_tt[i]  = tt;
            end else if (m_run[i] && m_k[i] < 1000) begin
                m_k[i] = m_k[i] + 1;
            end
        end
    end

    // Compare every output of both instances against the reference each cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int per, nv, comp, e_vec, e_err, e_fvec;
                bit e_busy, e_done, e_fv;
                logic [7:0] diff, seen;
                diff = m_tt[i] ^ EXP;
                per  = settle_of(i) + 1;
                nv   = vecs_in_run(diff);
                if (m_run[i]) begin
                    comp   = m_k[i] / per;
                    if (comp > nv) comp = nv;
                    e_busy = (m_k[i] < nv * per);
                    e_done = !e_busy;
                    e_vec  = e_busy ? (m_k[i] / per) : (nv - 1);
                end else begin
                    comp   = 0;
                    e_busy = 1'b0;
                    e_done = 1'b0;
                    e_vec  = 0;
                end
                seen   = diff & 8'((1 << comp) - 1);
                e_err  = $countones(seen);
                e_fv   = (seen != 8'd0);
                e_fvec = e_fv ? first_one(seen) : 0;
                chk($sformatf("vec%0d", i), int'({a_o[i], b_o[i], c_o[i]}), e_vec);
                chk($sformatf("busy%0d", i), int'(busy_o[i]), int'(e_busy));
                chk($sformatf("done%0d", i), int'(done_o[i]), int'(e_done));
                chk($sformatf("pass%0d", i), int'(pass_o[i]), int'(e_done && e_err == 0));
                chk($sformatf("err%0d", i), int'(err_o[i]), e_err);
                chk($sformatf("fvalid%0d", i), int'(fv_o[i]), int'(e_fv));
                chk($sformatf("fvec%0d", i), int'(fvec_o[i]), e_fvec);
            end
        end
    end

    // Called 1 time unit after a rising edge; returns 1 time unit after the edge sampling start.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Run one table; report the edge (start edge = 1) on which each done is first seen.
    task automatic run_table(input logic [7:0] t, output int e0, output int e1);
        tt = t;
        e0 = -1;
        e1 = -1;
        pulse_start();
        for (int n = 1; n <= 200; n++) begin
            if (e0 < 0 && done_o[0]) e0 = n;
            if (e1 < 0 && done_o[1]) e1 = n;
            if (e0 >= 0 && e1 >= 0) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 300 && busy_o != 2'b00; n++) begin
            @(posedge clk); #1;
        end
        chk("idle_wait", int'(busy_o), 0);
    endtask

    initial begin
        int e0, e1, gap;
        rst    = 1'b1;
        start  = 1'b0;
        tt     = EXP;
        chk_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 1'b0;
            m_k[i]   = 0;
            m_tt[i]  = EXP;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_err", int'(err_o[0]), 0);
        chk("rst_abc", int'({a_o[0], b_o[0], c_o[0]}), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Correct unit: full run, pass.
        run_table(EXP, e0, e1);
        chk("good_done_edge_s4", e0, 41);
        chk("good_done_edge_s1", e1, 17);
        chk("good_pass", int'(pass_o[0]), 1);
        chk("good_err", int'(err_o[0]), 0);
        chk("good_fvalid", int'(fv_o[0]), 0);

        // F stuck at 1: vectors 2, 5, 7 mismatch.
        run_table(8'hFF, e0, e1);
`ifdef TT_BIST_STOP_ON_FAIL_EN
        chk("stuck1_err", int'(err_o[0]), 1);
        chk("stuck1_done_edge_s4", e0, 16);
`else
        chk("stuck1_err", int'(err_o[0]), 3);
        chk("stuck1_done_edge_s4", e0, 41);
`endif
        chk("stuck1_fvec", int'(fvec_o[0]), 2);
        chk("stuck1_pass", int'(pass_o[0]), 0);
        wait_idle();

        // F inverted: every vector mismatches.
        run_table(~EXP, e0, e1);
`ifdef TT_BIST_STOP_ON_FAIL_EN
        chk("inv_err", int'(err_o[0]), 1);
`else
        chk("inv_err", int'(err_o[0]), 8);
`endif
        chk("inv_fvec", int'(fvec_o[0]), 0);
        chk("inv_fvalid", int'(fv_o[0]), 1);
        wait_idle();

        // Reset during vector 4, then a clean run.
        tt = EXP;
        pulse_start();
        repeat (21) begin @(posedge clk); #1; end
        chk("mid_vec4", int'({a_o[0], b_o[0], c_o[0]}), 4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_busy", int'(busy_o), 0);
        chk("mid_rst_abc", int'({a_o[0], b_o[0], c_o[0]}), 0);
        chk("mid_rst_err", int'(err_o[0]), 0);
        run_table(EXP, e0, e1);
        chk("after_rst_done_edge", e0, 41);
        chk("after_rst_pass", int'(pass_o[0]), 1);

        // Reset and start together: reset wins.
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_over_start", int'(busy_o), 0);

        // Start held high: runs back to back, never restarted while busy.
        tt    = 8'h5A;
        start = 1'b1;
        repeat (130) begin @(posedge clk); #1; end
        start = 1'b0;
        wait_idle();

        // Random tables with random start timing and stray start pulses.
        for (int r = 0; r < 14; r++) begin
            tt  = (r % 4 == 0) ? EXP : 8'($urandom);
            gap = int'($urandom_range(0, 3));
            repeat (gap) begin @(posedge clk); #1; end
            pulse_start();
            for (int c = 0; c < 60; c++) begin
                start = ($urandom_range(0, 7) == 0);
                @(posedge clk); #1;
            end
            start = 1'b0;
            wait_idle();
        end

        repeat (2) begin @(posedge clk); #1; end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
